avalon_mem_master: RTL
======================

# avalon_mem_master

CPU-side Avalon-MM master that turns one load/store request from the MIPS core's memory stage into a single word-addressed Avalon transfer on the data RAM. It sits directly upstream of the Avalon RAM slave. It generates byteenables, replicates store data, holds the bus stable while `waitrequest` is high, and returns sign- or zero-extended load data. Misaligned accesses are rejected without touching the bus; an optional watchdog aborts hung transfers.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum number of cycles `waitrequest` may stay high before the transfer is aborted; 0 disables the watchdog (16-bit counter).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend loads (LB/LH); 0 zero-extends (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: misaligned, illegal size, or timeout; valid with `resp_valid`.
- `address` out 32: Avalon word-aligned address `{req_addr[31:2],2'b00}`.
- `byteenable` out 4: Avalon lane enables.
- `read` out 1: Avalon read.
- `write` out 1: Avalon write.
- `writedata` out 32: Avalon write data.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, register all request fields.
    - If illegal or misaligned, go to RESP with the error flag set.
    - Otherwise drive `read`/`write`, `address`, `byteenable`, `writedata` from registers and go to BUS.
  - BUS: all Avalon outputs held constant. A transfer completes on a rising edge where `waitrequest`=0.
    - At completion, capture and extend `readdata` (loads only), deassert `read`/`write`, go to RESP.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Lane rules: little-endian; lane k is bits [8k+7:8k].
  - Byte: `byteenable` = 1<<addr[1:0]; `writedata` = byte replicated 4×.
  - Half: `byteenable` = addr[1] ? 1100 : 0011; `writedata` = halfword replicated 2×.
  - Word: `byteenable` = 1111; `writedata` = `req_wdata`.
- Load extract: shift `readdata` right by 8·addr[1:0], truncate to size, then extend per `req_signed`. Words pass through unchanged.
- Misaligned conditions:
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - `req_size`=11.
- Watchdog (`TIMEOUT_CYCLES`>0):
  - Counter clears on entry to BUS and increments each BUS cycle with `waitrequest`=1.
  - At count = `TIMEOUT_CYCLES`, drop `read`/`write` and go to RESP with `resp_error`=1 and `resp_rdata`=0.
- `read` and `write` are never high together.
- Only one outstanding transfer; no pipelining.

## Timing
- Reset (async assert, any state including mid-BUS):
  - State → IDLE.
  - `read`, `write`, `address`, `byteenable`, `writedata`, `resp_valid`, `resp_rdata`, `resp_error` all → 0.
  - `req_ready` → 1.
  - An in-flight transfer is dropped with no response.
- Accept edge: cycle 0. Bus asserted: cycle 1.
- Zero-wait slave (`waitrequest`=0 in cycle 1): `resp_valid` in cycle 2; minimum 3 cycles request-to-request.
- Each wait cycle adds one cycle of latency.
- Error without bus: accept in cycle 0, `resp_valid` in cycle 1; `read`/`write` never asserted.
- `req_ready`=0 from the cycle after accept until the cycle after `resp_valid`.
- `req_*` inputs are ignored outside IDLE.

## Structure
- Package `mem_pkg`:
  - `mem_size_t` enum (BYTE, HALF, WORD, ILLEGAL);
  - `mem_state_t` enum (IDLE, BUS, RESP);
  - constant `MEM_TIMEOUT_W` = 16.
- Sub-module `mem_lane_align` (combinational): byteenable generation, store replication, load extraction/extension, misalignment detect.
- FSM, registers and watchdog live in the top module.

## Test plan
- SW 0x100, data 0xDEADBEEF, slave waits 3 cycles → `write` high 4 cycles, `byteenable`=1111, `writedata`=0xDEADBEEF; `resp_valid` 1 cycle later, `resp_error`=0.
- SB 0x103, data 0x000000A5 → `address`=0x100, `byteenable`=1000, `writedata`=0xA5A5A5A5.
- LB signed 0x102, `readdata`=0x00800000 → `resp_rdata`=0xFFFFFF80; LBU same → 0x00000080.
- LH 0x101 → `resp_error`=1 in cycle 1, `read` never asserted; LW 0x102 → same.
- `TIMEOUT_CYCLES`=8, `waitrequest` stuck high → `read` drops after 8 stall cycles, `resp_error`=1, `resp_rdata`=0.
- `rst_n` low during BUS with `read` high → `read`=0 immediately (async), no `resp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the Avalon-MM load/store master.
package mem_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, ILLEGAL = 2'b11} mem_size_t;
    typedef enum logic [1:0] {IDLE, BUS, RESP} mem_state_t;
    localparam int MEM_TIMEOUT_W = 16;
endpackage

// File: rtl/avalon_mem_master_if.sv
// avalon_mem_master_if: word-addressed Avalon-MM bus between the CPU master and the data RAM.
interface avalon_mem_master_if;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    modport master (output address, byteenable, read, write, writedata, input waitrequest, readdata);
    modport slave  (input address, byteenable, read, write, writedata, output waitrequest, readdata);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane steering for stores, load extraction/extension, alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        sgn,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out,
    output logic        misaligned
);
    logic [31:0] sh;
    assign sh = rdata_in >> {addr_lo, 3'b000};
    assign byteenable = size == BYTE ? 4'b0001 << addr_lo : size == HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_out = size == BYTE ? {4{wdata_in[7:0]}} : size == HALF ? {2{wdata_in[15:0]}} : wdata_in;
    assign rdata_out = size == BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                       size == HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : rdata_in;
    assign misaligned = size == ILLEGAL || (size == HALF && addr_lo[0]) || (size == WORD && addr_lo != 2'b00);
endmodule

// File: rtl/avalon_mem_master.sv
// avalon_mem_master: turns one CPU load/store into a single Avalon-MM transfer with optional watchdog.
module avalon_mem_master
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    avalon_mem_master_if.master bus
);
    localparam logic [MEM_TIMEOUT_W-1:0] TO = TIMEOUT_CYCLES[MEM_TIMEOUT_W-1:0];

    mem_state_t state_q, state_d;
    mem_size_t  size_q, size_d;
    logic [1:0] lo_q, lo_d;
    logic       sgn_q, sgn_d, wr_q, wr_d, read_q, read_d, write_q, write_d, error_q, error_d;
    logic [31:0] address_q, address_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0] be_q, be_d;
    logic [MEM_TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic       idle, misaligned;
    logic [3:0] be;
    logic [31:0] wdata, rdata_ext;

    assign idle = state_q == IDLE;

    // In IDLE the aligner sees the live request; afterwards it sees the captured fields for load extraction.
    mem_lane_align u_align (
        .addr_lo   (idle ? req_addr[1:0] : lo_q),
        .size      (idle ? mem_size_t'(req_size) : size_q),
        .sgn       (idle ? req_signed : sgn_q),
        .wdata_in  (req_wdata),
        .rdata_in  (bus.readdata),
        .byteenable(be),
        .wdata_out (wdata),
        .rdata_out (rdata_ext),
        .misaligned(misaligned)
    );

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        lo_d      = lo_q;
        sgn_d     = sgn_q;
        wr_d      = wr_q;
        read_d    = read_q;
        write_d   = write_q;
        error_d   = error_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        be_d      = be_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                lo_d    = req_addr[1:0];
                size_d  = mem_size_t'(req_size);
                sgn_d   = req_signed;
                wr_d    = req_write;
                rdata_d = '0;
                error_d = misaligned;
                cnt_d   = '0;
                if (misaligned) begin
                    state_d = RESP;
                end else begin
                    state_d   = BUS;
                    read_d    = !req_write;
                    write_d   = req_write;
                    address_d = {req_addr[31:2], 2'b00};
                    be_d      = be;
                    wdata_d   = wdata;
                end
            end
            BUS: if (!bus.waitrequest) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                rdata_d = wr_q ? '0 : rdata_ext;
                state_d = RESP;
            end else if (TIMEOUT_CYCLES != 0) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == TO) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    error_d = 1'b1;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            size_q    <= BYTE;
            lo_q      <= '0;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            error_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            be_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            sgn_q     <= sgn_d;
            wr_q      <= wr_d;
            read_q    <= read_d;
            write_q   <= write_d;
            error_q   <= error_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            be_q      <= be_d;
            cnt_q     <= cnt_d;
        end
    end

    assign req_ready      = idle;
    assign resp_valid     = state_q == RESP;
    assign resp_rdata     = rdata_q;
    assign resp_error     = error_q;
    assign bus.address    = address_q;
    assign bus.byteenable = be_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.writedata  = wdata_q;
endmodule
